lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the memory stage of the pipelined core. It takes the effective address and store data from the execute/memory pipeline register and runs a req/gnt/rvalid transaction on the data-memory port. It produces the sign- or zero-extended load result `rdata3`, which the write-back stage consumes directly. While a transaction is outstanding it holds the pipeline with `lsu_stall`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `opr_res`  in  32  effective address (ALU result)
- `rdata2`  in  32  store data (rs2 value)
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `rd_en`  in  1  load request
- `wr_en`  in  1  store request
- `dm_req`  out  1  memory request
- `dm_we`  out  1  1 = store
- `dm_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`
- `dm_wdata`  out  32  lane-aligned store data
- `dm_be`  out  4  byte enables
- `dm_gnt`  in  1  request accepted
- `dm_rvalid`  in  1  load data valid
- `dm_rdata`  in  32  load data word
- `rdata3`  out  32  extended load result, registered
- `lsu_stall`  out  1  hold upstream stages
- `misalign`  out  1  misaligned-access flag

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `rd_en|wr_en`: latch `opr_res`, `rdata2`, `funct3` and op type, then go to REQ.
  - If both are asserted, the store wins.
- **REQ**
  - `dm_req=1`. Outputs come from latched values and stay stable until `dm_gnt`.
  - On `dm_gnt`: a store goes to DONE; a load goes to WAIT.
- **WAIT**
  - On `dm_rvalid`: extract and extend into `rdata3`, then go to DONE.
  - `dm_rvalid` seen in any state other than WAIT is ignored.
- **DONE**: lasts one cycle, then IDLE.
- `lsu_stall` = (IDLE & (`rd_en|wr_en`)) | REQ | WAIT. It is low in DONE, so the pipeline advances at the end of DONE.
- Store lanes:
  - SB: `dm_be = 4'b0001<<addr[1:0]`, `dm_wdata = {4{rdata2[7:0]}}`.
  - SH: `dm_be = addr[1] ? 1100 : 0011`, `dm_wdata = {2{rdata2[15:0]}}`.
  - SW: `dm_be = 1111`.
- Load extraction:
  - Byte lane is selected by `addr[1:0]`, halfword lane by `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend.
  - Any undefined `funct3` is treated as W.
- `rdata3` holds its value until the next load completes. Stores never change it.

## Timing
- Reset value of every output, plus the state, is 0; the FSM resets to IDLE.
- Reset is asynchronous mid-transaction: `dm_req` drops immediately and any in-flight response is dropped.
- Minimum load, with `dm_gnt` in the first REQ cycle and `dm_rvalid` the next cycle:
  - Cycle 0: IDLE, accept.
  - Cycle 1: REQ, gnt.
  - Cycle 2: WAIT, rvalid.
  - Cycle 3: DONE.
  - `lsu_stall` is high for cycles 0–2; `rdata3` is valid from cycle 3.
- Minimum store: IDLE, REQ(gnt), DONE. Stall lasts 2 cycles.
- `dm_gnt` wait states extend REQ; `dm_rvalid` wait states extend WAIT. Neither has a bound.
- Upstream holds its inputs stable while `lsu_stall=1`. Inputs are sampled only in IDLE.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined**
  - A misaligned access is detected in IDLE: H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`.
  - It issues no bus request and goes IDLE→DONE.
  - `misalign=1` during DONE only; `rdata3` is unchanged.
- **Undefined**
  - `misalign` is tied 0.
  - A misaligned access proceeds normally using the lane-select rules above: the low address bits below the access size are ignored.

## Test plan
- LW at 0x100, `dm_rdata=0xDEADBEEF`, gnt immediate, rvalid 1 cycle later -> `rdata3=0xDEADBEEF` in cycle 3; `lsu_stall` high for exactly cycles 0–2.
- LB at 0x103 with `dm_rdata=0x80123456` -> `0xFFFFFF80`; LBU same -> `0x00000080`; LHU at 0x102 -> `0x00008012`.
- SB at 0x201, `rdata2=0x000000AB` -> `dm_be=0010`, `dm_wdata=0xABABABAB`, `dm_we=1`, `dm_addr=0x200`; `rdata3` unchanged.
- `dm_gnt` low for 3 REQ cycles -> `dm_req` and `dm_addr`/`dm_wdata`/`dm_be` stable throughout; completion shifts by 3 cycles.
- `rst_n` low during WAIT -> all outputs 0 immediately; a `dm_rvalid` pulse arriving after reset release leaves `rdata3=0`.
- With `LSU_MISALIGN_TRAP_EN`: LW at 0x102 -> no `dm_req`, `misalign=1` for one cycle, stall 1 cycle. Without it: `dm_addr=0x100`, normal completion, `misalign=0`.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
//
// Load/store unit for the memory stage. It accepts an access from the
// EX/MEM pipeline register, runs one req/gnt/rvalid transaction on the
// data-memory port and returns the sign/zero-extended load result. The
// upstream pipeline is held with lsu_stall until the transaction finishes.
//
// Optional feature (compile-time macro): LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/W accesses issue no bus request, go straight
//               to DONE and raise misalign for that one cycle.
//   undefined : misalign is tied 0; low address bits below the access size
//               are ignored and the access proceeds normally.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   opr_res   [31:0] effective address
//   rdata2    [31:0] store data
//   funct3    [2:0]  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rd_en, wr_en     load / store request (store wins if both)
//   dm_req, dm_we    memory request / write strobe
//   dm_addr   [31:0] word-aligned address
//   dm_wdata  [31:0] lane-replicated store data
//   dm_be     [3:0]  byte enables
//   dm_gnt           request accepted
//   dm_rvalid        load data valid
//   dm_rdata  [31:0] load data word
//   rdata3    [31:0] extended load result (registered)
//   lsu_stall        hold upstream stages
//   misalign         misaligned-access flag
// -----------------------------------------------------------------------------
module lsu_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] opr_res,
   input  logic [31:0] rdata2,
   input  logic [2:0]  funct3,
   input  logic        rd_en,
   input  logic        wr_en,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic        dm_gnt,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic [31:0] rdata3,
   output logic        lsu_stall,
   output logic        misalign
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } size_t;

   // Undefined funct3 encodings fall through to a full word access.
   function automatic size_t size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: size_of = SZ_B;
         3'b001, 3'b101: size_of = SZ_H;
         default:        size_of = SZ_W;
      endcase
   endfunction

   state_t      state, state_nxt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  f3_q;
   logic        we_q;
   logic        req_in;
   logic        mis_in;
   logic        in_req;
   logic [3:0]  be_c;
   logic [31:0] wd_c;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sgn;
   logic [31:0] load_ext;

   assign req_in = rd_en | wr_en;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      mis_in = 1'b0;
      case (size_of(funct3))
         SZ_H:    mis_in = opr_res[0];
         SZ_W:    mis_in = |opr_res[1:0];
         default: mis_in = 1'b0;
      endcase
   end
`else
   assign mis_in = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt is given a default before the case so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_in)    state_nxt = mis_in ? DONE : REQ;
         REQ:  if (dm_gnt)    state_nxt = we_q ? DONE : WAIT;
         WAIT: if (dm_rvalid) state_nxt = DONE;
         DONE:                state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------ access capture
   // NOTE: the captured access is reset along with the FSM so that the bus
   // outputs derived from it read 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
      end else if (state == IDLE && req_in) begin
         addr_q  <= opr_res;
         wdata_q <= rdata2;
         f3_q    <= funct3;
         we_q    <= wr_en;
      end
   end

   // ------------------------------------------------------ store lanes
   always_comb begin
      be_c = 4'b1111;
      wd_c = wdata_q;
      case (size_of(f3_q))
         SZ_B: begin
            be_c = 4'b0001 << addr_q[1:0];
            wd_c = {4{wdata_q[7:0]}};
         end
         SZ_H: begin
            be_c = addr_q[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{wdata_q[15:0]}};
         end
         default: begin
            be_c = 4'b1111;
            wd_c = wdata_q;
         end
      endcase
   end

   // Bus outputs are driven only while the request is presented, so they
   // are quiet (and 0) in every other state, including right after reset.
   assign in_req    = (state == REQ);
   assign dm_req    = in_req;
   assign dm_we     = in_req & we_q;
   assign dm_addr   = in_req ? {addr_q[31:2], 2'b00} : '0;
   assign dm_be     = in_req ? be_c : '0;
   assign dm_wdata  = in_req ? wd_c : '0;
   assign lsu_stall = ((state == IDLE) & req_in) | (state == REQ) | (state == WAIT);

   // ------------------------------------------------------ load extraction
   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_sel = dm_rdata[7:0];
         2'd1:    byte_sel = dm_rdata[15:8];
         2'd2:    byte_sel = dm_rdata[23:16];
         default: byte_sel = dm_rdata[31:24];
      endcase
      half_sel = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      // funct3[2] set means the unsigned (BU/HU) variant.
      sgn      = ~f3_q[2];
      case (size_of(f3_q))
         SZ_B:    load_ext = {{24{sgn & byte_sel[7]}}, byte_sel};
         SZ_H:    load_ext = {{16{sgn & half_sel[15]}}, half_sel};
         default: load_ext = dm_rdata;
      endcase
   end

   // Only a response in WAIT updates the result; stray rvalid is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          rdata3 <= '0;
      else if (state == WAIT && dm_rvalid) rdata3 <= load_ext;
   end

   // ------------------------------------------------------ misalign flag
`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             mis_q <= 1'b0;
      else if (state == IDLE) mis_q <= req_in & mis_in;
   end

   assign misalign = (state == DONE) & mis_q;
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
//
// Self-checking bench for lsu_mem_stage: a table of directed accesses, a
// mid-transaction reset sequence, and randomized accesses compared against
// a byte-level reference model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] opr_res;
   logic [31:0] rdata2;
   logic [2:0]  funct3;
   logic        rd_en;
   logic        wr_en;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic [31:0] rdata3;
   logic        lsu_stall;
   logic        misalign;

   lsu_mem_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opr_res   (opr_res),
      .rdata2    (rdata2),
      .funct3    (funct3),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_be     (dm_be),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .rdata3    (rdata3),
      .lsu_stall (lsu_stall),
      .misalign  (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_load = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------ reference model
   function automatic int size_bytes(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      int          n;
      int          lane;
      logic [31:0] v;
      n = size_bytes(f3);
      if (n == 4) return w;
      lane = (n == 1) ? int'(a[1:0]) : 2 * int'(a[1]);
      v = (w >> (8 * lane)) & ((32'h1 << (8 * n)) - 1);
      if (!f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      int         n;
      int         lo;
      logic [3:0] be;
      n  = size_bytes(f3);
      lo = (n == 1) ? int'(a[1:0]) : (n == 2) ? 2 * int'(a[1]) : 0;
      for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + n);
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      int          n;
      logic [31:0] wd;
      n = size_bytes(f3);
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % n) +: 8];
      return wd;
   endfunction

   function automatic bit model_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (int'(a[1:0]) % size_bytes(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // ------------------------------------------------ one full transaction
   // Drives one access starting in IDLE, acts as the memory (g gnt-low
   // cycles, r rvalid wait cycles, optional stray rvalid noise outside WAIT)
   // and checks bus values, stall length, result and misalign flag.
   task automatic do_op(input string name, input logic we, input logic both,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] word,
                        input int g, input int r, input bit noise, input bit trap,
                        input logic [31:0] exp_rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
      int          stalls    = 0;
      int          reqs      = 0;
      int          waitn     = 0;
      int          cyc       = 0;
      bit          phase     = 0;
      bit          granted;
      bit          done      = 0;
      bit          bus_ok    = 1;
      bit          mis_early = 0;
      bit          timeout   = 0;
      int          exp_stall;
      logic [31:0] exp_addr;
      exp_addr  = {addr[31:2], 2'b00};
      exp_stall = trap ? 1 : (we ? 2 + g : 3 + g + r);
      opr_res = addr;
      rdata2  = data;
      funct3  = f3;
      wr_en   = we;
      rd_en   = !we || both;
      while (!done) begin
         #1;
         if (cyc > 0 && !lsu_stall) begin
            done = 1;
         end else begin
            if (lsu_stall) stalls++;
            if (misalign) mis_early = 1;
            granted = 0;
            if (dm_req) begin
               if (dm_addr !== exp_addr || dm_we !== we ||
                   (we && (dm_be !== exp_be || dm_wdata !== exp_wd))) bus_ok = 0;
               dm_gnt  = (reqs == g);
               granted = dm_gnt;
               reqs++;
            end else begin
               dm_gnt = 1'b0;
            end
            if (phase) begin
               dm_rvalid = (waitn == r);
               dm_rdata  = dm_rvalid ? word : $urandom;
               waitn++;
            end else begin
               dm_rvalid = noise && ($urandom_range(1) == 1);
               dm_rdata  = $urandom;
            end
            @(posedge clk);
            if (granted && !we) phase = 1;
            cyc++;
            if (cyc > 50) begin
               timeout = 1;
               done    = 1;
            end
         end
      end
      check({name, " timeout"}, 32'(timeout), 32'd0);
      check({name, " stall cycles"}, stalls, exp_stall);
      check({name, " req cycles"}, reqs, trap ? 0 : g + 1);
      check({name, " bus values"}, 32'(bus_ok), 32'd1);
      check({name, " rdata3"}, rdata3, exp_rd);
      check({name, " misalign"}, {30'd0, mis_early, misalign}, {31'd0, trap});
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------ directed table
   typedef struct {
      string       name;
      logic        we;
      logic        both;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] word;
      int          g;
      int          r;
      logic [31:0] exp_rd;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [2:0]  ld_f3 [8];
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] w;
      logic        we;
      bit          tr;

      vecs[0]  = '{"lw_100",  0, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'h0, 32'h0};
      vecs[1]  = '{"lb_103",  0, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, 32'hFFFFFF80, 4'h0, 32'h0};
      vecs[2]  = '{"lbu_103", 0, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 0, 32'h00000080, 4'h0, 32'h0};
      vecs[3]  = '{"lhu_102", 0, 0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 0, 32'h00008012, 4'h0, 32'h0};
      vecs[4]  = '{"sb_201",  1, 0, 3'b000, 32'h201, 32'hAB, 32'h0, 0, 0, 32'h00008012, 4'b0010, 32'hABABABAB};
      vecs[5]  = '{"lh_gnt3", 0, 0, 3'b001, 32'h100, 32'h0, 32'h0000F00D, 3, 2, 32'hFFFFF00D, 4'h0, 32'h0};
      vecs[6]  = '{"sh_gnt3", 1, 0, 3'b001, 32'h202, 32'h00001234, 32'h0, 3, 0, 32'hFFFFF00D, 4'b1100, 32'h12341234};
      vecs[7]  = '{"sw_both", 1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1, 0, 32'hFFFFF00D, 4'b1111, 32'hCAFEF00D};
      vecs[8]  = '{"lb_101",  0, 0, 3'b000, 32'h101, 32'h0, 32'h12347F56, 0, 1, 32'h0000007F, 4'h0, 32'h0};
      vecs[9]  = '{"l_f3_011", 0, 0, 3'b011, 32'h010, 32'h0, 32'h89ABCDEF, 2, 0, 32'h89ABCDEF, 4'h0, 32'h0};
      vecs[10] = '{"lh_202",  0, 0, 3'b001, 32'h202, 32'h0, 32'h80011234, 0, 3, 32'hFFFF8001, 4'h0, 32'h0};

      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

      rst_n     = 1'b0;
      opr_res   = '0;
      rdata2    = '0;
      funct3    = '0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      dm_rdata  = '0;

      // Reset state.
      #3;
      check("reset dm_req", 32'(dm_req), 32'd0);
      check("reset bus", dm_addr | dm_wdata | {28'd0, dm_be} | {31'd0, dm_we}, 32'd0);
      check("reset rdata3", rdata3, 32'd0);
      check("reset stall/misalign", {30'd0, lsu_stall, misalign}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors.
      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].name, vecs[i].we, vecs[i].both, vecs[i].f3, vecs[i].addr,
               vecs[i].data, vecs[i].word, vecs[i].g, vecs[i].r, 1'b0, 1'b0,
               vecs[i].exp_rd, vecs[i].exp_be, vecs[i].exp_wd);
      end
      last_load = 32'hFFFF8001;

      // Reset asserted while a load waits for its response.
      opr_res = 32'h300;
      funct3  = 3'b010;
      rd_en   = 1'b1;
      wr_en   = 1'b0;
      @(posedge clk);
      #1;
      dm_gnt = 1'b1;
      @(posedge clk);
      #1;
      dm_gnt = 1'b0;
      check("wait stall", 32'(lsu_stall), 32'd1);
      rst_n = 1'b0;
      rd_en = 1'b0;
      #1;
      check("async rst dm_req", 32'(dm_req), 32'd0);
      check("async rst rdata3", rdata3, 32'd0);
      check("async rst stall", 32'(lsu_stall), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h5555AAAA;
      @(posedge clk);
      #1;
      dm_rvalid = 1'b0;
      check("late rvalid rdata3", rdata3, 32'd0);
      check("late rvalid idle", {30'd0, lsu_stall, dm_req}, 32'd0);
      last_load = '0;

      // Misaligned word load.
      tr = model_trap(3'b010, 32'h102);
      do_op("lw_102", 1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 0, 1'b0, tr,
            tr ? last_load : 32'h11223344, 4'h0, 32'h0);
      if (!tr) last_load = 32'h11223344;

      // Randomized accesses against the model.
      for (int i = 0; i < 40; i++) begin
         we = ($urandom_range(2) == 0);
         f3 = we ? 3'($urandom_range(2)) : ld_f3[$urandom_range(7)];
         a  = $urandom;
         d  = $urandom;
         w  = $urandom;
         tr = model_trap(f3, a);
         do_op($sformatf("rnd%0d", i), we, we && ($urandom_range(1) == 1), f3, a, d, w,
               $urandom_range(3), $urandom_range(3), 1'b1, tr,
               (we || tr) ? last_load : model_load(f3, a, w),
               model_be(f3, a), model_wdata(f3, d));
         if (!we && !tr) last_load = model_load(f3, a, w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
